// File: rtl/memorystage1.sv
// Memory-access pipeline stage: effective address, one handshaked bus cycle, lane-aligned loads.
// Optional bus wait timeout enabled by defining MEMORYSTAGE1_TIMEOUT_EN.
module memorystage1
`ifdef MEMORYSTAGE1_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inbound_instruction,
  output logic [3:0]  reg_read_index_a,
  output logic [3:0]  reg_read_index_b,
  input  logic [31:0] reg_data_a,
  input  logic [31:0] reg_data_b,
  output logic        stall,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  output logic [3:0]  bus_byte_enables,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_ready,
  output logic        alignment_error,
  output logic [31:0] load_data,
  output logic [31:0] outbound_instruction
`ifdef MEMORYSTAGE1_TIMEOUT_EN
  ,
  output logic        bus_timeout
`endif
);

  localparam logic [4:0] OPCODE_NOP   = 5'h00;
  localparam logic [4:0] OPCODE_LOAD  = 5'h01;
  localparam logic [4:0] OPCODE_STORE = 5'h02;
  localparam logic [1:0] CW_BYTE      = 2'b00;
  localparam logic [1:0] CW_WORD      = 2'b01;
  localparam logic [1:0] CW_LONG      = 2'b10;
  localparam logic [31:0] NOP_INSTR   = {OPCODE_NOP, 27'h0};

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dout_q, dout_d;
  logic [3:0]  be_q, be_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        align_q, align_d;
  logic [31:0] load_q, load_d;
  logic [31:0] out_q, out_d;
  logic [31:0] instr_q, instr_d;

  logic [4:0]  opcode;
  logic [1:0]  width;
  logic [31:0] ea;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] dout_new;
  logic [7:0]  rd_byte;
  logic [15:0] rd_word;
  logic [31:0] rd_lane;

`ifdef MEMORYSTAGE1_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_q, wait_d;
  logic            timeout_q, timeout_d;
  assign bus_timeout = timeout_q;
`endif

  assign opcode           = inbound_instruction[31:27];
  assign width            = inbound_instruction[26:25];
  assign reg_read_index_a = inbound_instruction[19:16];
  assign reg_read_index_b = inbound_instruction[23:20];
  assign ea               = reg_data_a + {{16{inbound_instruction[15]}}, inbound_instruction[15:0]};
  assign is_mem           = (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
  // Width code 2'b11 is treated as a long access.
  assign misaligned       = ((width == CW_WORD) && ea[0]) || (width[1] && (ea[1:0] != 2'b00));

  always_comb begin
    be_new   = 4'b1111;
    dout_new = reg_data_b;
    case (width)
      CW_BYTE: begin
        be_new   = 4'b1000 >> ea[1:0];
        dout_new = {4{reg_data_b[7:0]}};
      end
      CW_WORD: begin
        be_new   = ea[1] ? 4'b0011 : 4'b1100;
        dout_new = {2{reg_data_b[15:0]}};
      end
      default: ;
    endcase
  end

  // Big-endian lanes: address offset 0 is bits 31:24.
  always_comb begin
    unique case (addr_q[1:0])
      2'd0: rd_byte = bus_data_in[31:24];
      2'd1: rd_byte = bus_data_in[23:16];
      2'd2: rd_byte = bus_data_in[15:8];
      2'd3: rd_byte = bus_data_in[7:0];
    endcase
    rd_word = addr_q[1] ? bus_data_in[15:0] : bus_data_in[31:16];
    case (instr_q[26:25])
      CW_BYTE: rd_lane = {24'h0, rd_byte};
      CW_WORD: rd_lane = {16'h0, rd_word};
      default: rd_lane = bus_data_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    be_d    = be_q;
    read_d  = read_q;
    write_d = write_q;
    align_d = 1'b0;
    load_d  = load_q;
    out_d   = NOP_INSTR;
    instr_d = instr_q;
    stall   = 1'b0;
`ifdef MEMORYSTAGE1_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        out_d = inbound_instruction;
        if (is_mem) begin
          out_d = NOP_INSTR;
          if (misaligned) begin
            align_d = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = ea;
            be_d    = be_new;
            dout_d  = dout_new;
            read_d  = (opcode == OPCODE_LOAD);
            write_d = (opcode == OPCODE_STORE);
            instr_d = inbound_instruction;
            state_d = StAccess;
`ifdef MEMORYSTAGE1_TIMEOUT_EN
            wait_d  = '0;
`endif
          end
        end
      end
      StAccess: begin
        if (bus_ready) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          be_d    = 4'b0000;
          out_d   = instr_q;
          state_d = StIdle;
          if (instr_q[31:27] == OPCODE_LOAD) load_d = rd_lane;
        end else begin
          stall = 1'b1;
`ifdef MEMORYSTAGE1_TIMEOUT_EN
          if (wait_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            stall     = 1'b0;
            read_d    = 1'b0;
            write_d   = 1'b0;
            be_d      = 4'b0000;
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + CntW'(1);
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dout_q  <= '0;
      be_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      align_q <= 1'b0;
      load_q  <= '0;
      out_q   <= NOP_INSTR;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      be_q    <= be_d;
      read_q  <= read_d;
      write_q <= write_d;
      align_q <= align_d;
      load_q  <= load_d;
      out_q   <= out_d;
      instr_q <= instr_d;
    end
  end

`ifdef MEMORYSTAGE1_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign bus_address          = addr_q;
  assign bus_data_out         = dout_q;
  assign bus_byte_enables     = be_q;
  assign bus_read             = read_q;
  assign bus_write            = write_q;
  assign alignment_error      = align_q;
  assign load_data            = load_q;
  assign outbound_instruction = out_q;

endmodule

// File: tb/tb_memorystage1.sv
// Directed bench for memorystage1: stimulus pushes expected stage-2 outputs into a scoreboard,
// a negedge monitor pops and compares them; bus-side signals are checked inline.
module tb_memorystage1;

  localparam logic [4:0] OP_NOP = 5'h00, OP_LOAD = 5'h01, OP_STORE = 5'h02, OP_ADD = 5'h03;
  localparam logic [1:0] W_BYTE = 2'b00, W_WORD = 2'b01, W_LONG = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inbound_instruction;
  logic [3:0]  reg_read_index_a, reg_read_index_b;
  logic [31:0] reg_data_a, reg_data_b;
  logic        stall;
  logic [31:0] bus_address, bus_data_out, bus_data_in;
  logic [3:0]  bus_byte_enables;
  logic        bus_read, bus_write, bus_ready;
  logic        alignment_error;
  logic [31:0] load_data, outbound_instruction;
`ifdef MEMORYSTAGE1_TIMEOUT_EN
  logic        bus_timeout;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] load;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_load = 32'h0;

  memorystage1 dut (
    .clock(clock), .reset(reset), .inbound_instruction(inbound_instruction),
    .reg_read_index_a(reg_read_index_a), .reg_read_index_b(reg_read_index_b),
    .reg_data_a(reg_data_a), .reg_data_b(reg_data_b), .stall(stall),
    .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_byte_enables(bus_byte_enables), .bus_read(bus_read), .bus_write(bus_write),
    .bus_ready(bus_ready), .alignment_error(alignment_error), .load_data(load_data),
`ifdef MEMORYSTAGE1_TIMEOUT_EN
    .bus_timeout(bus_timeout),
`endif
    .outbound_instruction(outbound_instruction)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] w,
                                     input logic [3:0] rb, input logic [3:0] ra,
                                     input logic [15:0] off);
    return {op, w, 1'b0, rb, ra, off};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every non-NOP instruction leaving the stage must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && outbound_instruction !== 32'h0) begin
        if (sb.size() == 0) begin
          chk("unexpected_outbound", outbound_instruction, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("outbound_instr", outbound_instruction, e.instr);
          chk("outbound_load_data", load_data, e.load);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the completing edge.
  task automatic do_mem(input string name, input logic [31:0] instr, input logic [31:0] base,
                        input logic [31:0] bdata, input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_dout, input logic [31:0] exp_load);
    logic is_load;
    exp_t e;
    is_load = (instr[31:27] == OP_LOAD);
    inbound_instruction = instr;
    reg_data_a = base;
    reg_data_b = bdata;
    bus_ready = 1'b0;
    @(negedge clock);
    chk({name, "_stall_idle"}, 32'(stall), 32'h1);
    @(posedge clock); #1;
    chk({name, "_addr"}, bus_address, exp_addr);
    chk({name, "_be"}, 32'(bus_byte_enables), 32'(exp_be));
    chk({name, "_dout"}, bus_data_out, exp_dout);
    chk({name, "_read"}, 32'(bus_read), 32'(is_load));
    chk({name, "_write"}, 32'(bus_write), 32'(!is_load));
    chk({name, "_bubble"}, outbound_instruction, 32'h0);
    for (int i = 0; i < waits; i++) begin
      chk({name, "_stall_wait"}, 32'(stall), 32'h1);
      @(posedge clock); #1;
      chk({name, "_strobe_held"}, 32'(bus_read | bus_write), 32'h1);
    end
    bus_ready = 1'b1;
    bus_data_in = rdata;
    #1;
    chk({name, "_stall_done"}, 32'(stall), 32'h0);
    if (is_load) last_load = exp_load;
    e.instr = instr;
    e.load = last_load;
    sb.push_back(e);
    @(posedge clock); #1;
    bus_ready = 1'b0;
    inbound_instruction = 32'h0;
    chk({name, "_strobe_drop"}, 32'({bus_read, bus_write, bus_byte_enables}), 32'h0);
  endtask

  task automatic do_misaligned(input string name, input logic [31:0] instr,
                               input logic [31:0] base);
    inbound_instruction = instr;
    reg_data_a = base;
    @(negedge clock);
    chk({name, "_no_stall"}, 32'(stall), 32'h0);
    @(posedge clock); #1;
    chk({name, "_align_err"}, 32'(alignment_error), 32'h1);
    chk({name, "_no_strobe"}, 32'({bus_read, bus_write}), 32'h0);
    chk({name, "_nop_out"}, outbound_instruction, 32'h0);
    inbound_instruction = 32'h0;
    @(posedge clock); #1;
    chk({name, "_align_pulse"}, 32'(alignment_error), 32'h0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ld1;
    reset = 1'b0;
    inbound_instruction = 32'h0;
    reg_data_a = 32'h0;
    reg_data_b = 32'h0;
    bus_data_in = 32'h0;
    bus_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outbound", outbound_instruction, 32'h0);
    chk("rst_bus", 32'({bus_read, bus_write, bus_byte_enables}), 32'h0);
    chk("rst_addr", bus_address, 32'h0);
    chk("rst_dout", bus_data_out, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_align", 32'(alignment_error), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    ld1 = mk(OP_LOAD, W_LONG, 4'd2, 4'd1, 16'h0004);
    inbound_instruction = ld1;
    #1;
    chk("idx_a", 32'(reg_read_index_a), 32'd1);
    chk("idx_b", 32'(reg_read_index_b), 32'd2);
    do_mem("t1", ld1, 32'h1000, 32'h0, 2, 32'hDEADBEEF, 32'h1004, 4'b1111, 32'h0,
           32'hDEADBEEF);
    do_mem("t2b3", mk(OP_LOAD, W_BYTE, 4'd0, 4'd1, 16'h0003), 32'h1000, 32'h0, 0,
           32'h11223344, 32'h1003, 4'b0001, 32'h0, 32'h44);
    do_mem("t2b0", mk(OP_LOAD, W_BYTE, 4'd0, 4'd1, 16'h0000), 32'h1000, 32'h0, 1,
           32'h11223344, 32'h1000, 4'b1000, 32'h0, 32'h11);
    do_mem("t2w2", mk(OP_LOAD, W_WORD, 4'd0, 4'd1, 16'h0002), 32'h1000, 32'h0, 0,
           32'h11223344, 32'h1002, 4'b0011, 32'h0, 32'h3344);
    do_mem("t3", mk(OP_STORE, W_WORD, 4'd3, 4'd4, 16'h0002), 32'h2000, 32'h0000ABCD, 1,
           32'hFFFFFFFF, 32'h2002, 4'b0011, 32'hABCDABCD, 32'h0);
    do_mem("stb", mk(OP_STORE, W_BYTE, 4'd3, 4'd4, 16'h0001), 32'h2000, 32'h123456EF, 0,
           32'h0, 32'h2001, 4'b0100, 32'hEFEFEFEF, 32'h0);
    do_mem("negoff", mk(OP_LOAD, W_LONG, 4'd0, 4'd5, 16'hFFF0), 32'h1010, 32'h0, 0,
           32'hCAFEF00D, 32'h1000, 4'b1111, 32'h0, 32'hCAFEF00D);
    do_mem("wrap", mk(OP_LOAD, W_WORD, 4'd0, 4'd5, 16'h0004), 32'hFFFFFFFE, 32'h0, 0,
           32'h89ABCDEF, 32'h00000002, 4'b0011, 32'h0, 32'hCDEF);

    // Non-memory pass-through; bus_ready asserted in IDLE must be ignored.
    inbound_instruction = mk(OP_ADD, 2'b00, 4'd7, 4'd6, 16'h1234);
    bus_ready = 1'b1;
    e.instr = inbound_instruction;
    e.load = last_load;
    sb.push_back(e);
    #1;
    chk("alu_no_stall", 32'(stall), 32'h0);
    @(posedge clock); #1;
    chk("alu_no_strobe", 32'({bus_read, bus_write}), 32'h0);
    inbound_instruction = 32'h0;
    bus_ready = 1'b0;
    @(posedge clock); #1;

    do_misaligned("t4", mk(OP_LOAD, W_LONG, 4'd0, 4'd1, 16'h0002), 32'h1000);
    do_misaligned("mis_w", mk(OP_STORE, W_WORD, 4'd0, 4'd1, 16'h0001), 32'h1000);

    // Reset in the second ACCESS cycle abandons the load.
    inbound_instruction = ld1;
    reg_data_a = 32'h1000;
    bus_ready = 1'b0;
    @(posedge clock); #1;
    chk("t5_access", 32'(bus_read), 32'h1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("t5_strobe_drop", 32'({bus_read, bus_byte_enables}), 32'h0);
    chk("t5_outbound", outbound_instruction, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    last_load = 32'h0;
    do_mem("t5_rerun", ld1, 32'h1000, 32'h0, 1, 32'h0BADF00D, 32'h1004, 4'b1111, 32'h0,
           32'h0BADF00D);

`ifdef MEMORYSTAGE1_TIMEOUT_EN
    // Ready never arrives: timeout after 16 ACCESS cycles.
    inbound_instruction = ld1;
    reg_data_a = 32'h1000;
    @(posedge clock); #1;
    for (int i = 1; i < 16; i++) begin
      @(posedge clock); #1;
    end
    chk("t6_held", 32'(bus_read), 32'h1);
    @(posedge clock); #1;
    inbound_instruction = 32'h0;
    chk("t6_timeout", 32'(bus_timeout), 32'h1);
    chk("t6_drop", 32'(bus_read), 32'h0);
    chk("t6_nop", outbound_instruction, 32'h0);
    chk("t6_load_kept", load_data, last_load);
    @(posedge clock); #1;
    chk("t6_pulse", 32'(bus_timeout), 32'h0);
    // Ready on the terminal cycle completes normally.
    inbound_instruction = ld1;
    @(posedge clock); #1;
    for (int i = 1; i < 16; i++) begin
      @(posedge clock); #1;
    end
    bus_ready = 1'b1;
    bus_data_in = 32'h76543210;
    last_load = 32'h76543210;
    e.instr = ld1;
    e.load = last_load;
    sb.push_back(e);
    @(posedge clock); #1;
    bus_ready = 1'b0;
    inbound_instruction = 32'h0;
    chk("t6_no_timeout", 32'(bus_timeout), 32'h0);
`endif

    repeat (3) @(posedge clock);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
